// File: rtl/fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : fwd_hazard_unit
// Brief    : Tracks in-flight destinations and produces EX forward selects and
//            an ID load-use stall. The optional FWD_HAZARD_STATS_EN macro adds
//            stall and forward event counters.
// Revision : 1.0 - initial release
// ============================================================================
module fwd_hazard_unit #(
  parameter int REG_AW    = 5,
  parameter int NUM_SRC   = 2,
  parameter int FWD_DEPTH = 2,
  parameter int LOAD_LAT  = 1
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic                                    id_valid_i,
  input  logic [NUM_SRC*REG_AW-1:0]               id_rs_i,
  input  logic [REG_AW-1:0]                       id_rd_i,
  input  logic                                    id_regwrite_i,
  input  logic                                    id_load_i,
  input  logic                                    flush_i,
  input  logic                                    mem_stall_i,
  output logic [NUM_SRC*$clog2(FWD_DEPTH+1)-1:0]  fwd_sel_o,
  output logic                                    stall_id_o
`ifdef FWD_HAZARD_STATS_EN
  ,
  output logic [31:0]                             stall_cnt_o,
  output logic [31:0]                             fwd_cnt_o
`endif
);

  localparam int C_SELW = $clog2(FWD_DEPTH + 1);

  logic                      r_ex_v;
  logic                      r_ex_we;
  logic                      r_ex_ld;
  logic [REG_AW-1:0]         r_ex_rd;
  logic [NUM_SRC*REG_AW-1:0] r_ex_rs;

  logic [FWD_DEPTH-1:0]      r_ent_v;
  logic [FWD_DEPTH-1:0]      r_ent_we;
  logic [FWD_DEPTH-1:0]      r_ent_ld;
  logic [REG_AW-1:0]         r_ent_rd [FWD_DEPTH];

  logic                      w_ex_wr;
  logic [FWD_DEPTH-1:0]      w_ent_wr;
  logic                      w_capture;

  // Register 0 is hard-wired, so a write to it is never a producer.
  assign w_ex_wr = r_ex_v && r_ex_we && (r_ex_rd != '0);

  generate
    for (genvar g = 0; g < FWD_DEPTH; g++) begin : g_wr
      assign w_ent_wr[g] = r_ent_v[g] && r_ent_we[g] && (r_ent_rd[g] != '0);
    end
  endgenerate

  assign w_capture = id_valid_i && !flush_i && !stall_id_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ex_v   <= 1'b0;
      r_ex_we  <= 1'b0;
      r_ex_ld  <= 1'b0;
      r_ex_rd  <= '0;
      r_ex_rs  <= '0;
      r_ent_v  <= '0;
      r_ent_we <= '0;
      r_ent_ld <= '0;
      for (int k = 0; k < FWD_DEPTH; k++) begin
        r_ent_rd[k] <= '0;
      end
    end else if (!mem_stall_i) begin
      for (int k = FWD_DEPTH - 1; k >= 1; k--) begin
        r_ent_v[k]  <= r_ent_v[k-1];
        r_ent_we[k] <= r_ent_we[k-1];
        r_ent_ld[k] <= r_ent_ld[k-1];
        r_ent_rd[k] <= r_ent_rd[k-1];
      end
      r_ent_v[0]  <= r_ex_v;
      r_ent_we[0] <= r_ex_we;
      r_ent_ld[0] <= r_ex_ld;
      r_ent_rd[0] <= r_ex_rd;
      if (w_capture) begin
        r_ex_v  <= 1'b1;
        r_ex_we <= id_regwrite_i;
        r_ex_ld <= id_load_i;
        r_ex_rd <= id_rd_i;
        r_ex_rs <= id_rs_i;
      end else begin
        // Bubble sources are zeroed so an empty EX slot never requests a forward.
        r_ex_v  <= 1'b0;
        r_ex_we <= 1'b0;
        r_ex_ld <= 1'b0;
        r_ex_rd <= '0;
        r_ex_rs <= '0;
      end
    end
  end

  // Scan oldest to youngest so the nearest matching writer overrides.
  always_comb begin
    fwd_sel_o = '0;
    for (int n = 0; n < NUM_SRC; n++) begin
      for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
        if (w_ent_wr[k] && (r_ent_rd[k] == r_ex_rs[n*REG_AW +: REG_AW])) begin
          if (!r_ent_ld[k] || (k >= LOAD_LAT)) begin
            fwd_sel_o[n*C_SELW +: C_SELW] = C_SELW'(k + 1);
          end else begin
            fwd_sel_o[n*C_SELW +: C_SELW] = '0;
          end
        end
      end
    end
  end

  // A producer in entry k sits at entry k+1 once the consumer reaches EX.
  always_comb begin
    logic              hz;
    logic [REG_AW-1:0] src;
    stall_id_o = 1'b0;
    hz         = 1'b0;
    src        = '0;
    for (int n = 0; n < NUM_SRC; n++) begin
      hz  = 1'b0;
      src = id_rs_i[n*REG_AW +: REG_AW];
      for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
        if (w_ent_wr[k] && (r_ent_rd[k] == src)) begin
          hz = r_ent_ld[k] && ((k + 1) < LOAD_LAT);
        end
      end
      if (w_ex_wr && (r_ex_rd == src)) begin
        hz = r_ex_ld && (LOAD_LAT >= 1);
      end
      if (id_valid_i && (src != '0) && hz) begin
        stall_id_o = 1'b1;
      end
    end
  end

`ifdef FWD_HAZARD_STATS_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_fwd_cnt;
  logic        w_any_fwd;

  assign w_any_fwd = |fwd_sel_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_stall_cnt <= '0;
      r_fwd_cnt   <= '0;
    end else if (!mem_stall_i) begin
      if (stall_id_o && (r_stall_cnt != 32'hFFFF_FFFF)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if (w_any_fwd && (r_fwd_cnt != 32'hFFFF_FFFF)) begin
        r_fwd_cnt <= r_fwd_cnt + 32'd1;
      end
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign fwd_cnt_o   = r_fwd_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fwd_hazard_unit
// Brief    : Directed scoreboard bench for fwd_hazard_unit (two configurations).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fwd_hazard_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [9:0] id_rs;
  logic [4:0] id_rd;
  logic       id_regwrite;
  logic       id_load;
  logic       flush;
  logic       mem_stall;
  logic [3:0] sel_a;
  logic [3:0] sel_b;
  logic       stall_a;
  logic       stall_b;
`ifdef FWD_HAZARD_STATS_EN
  logic [31:0] scnt_a, fcnt_a, scnt_b, fcnt_b;
`endif

  always #5 clk = ~clk;

  fwd_hazard_unit #(.REG_AW(5), .NUM_SRC(2), .FWD_DEPTH(2), .LOAD_LAT(1)) dut_a (
    .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_rs_i(id_rs), .id_rd_i(id_rd),
    .id_regwrite_i(id_regwrite), .id_load_i(id_load), .flush_i(flush),
    .mem_stall_i(mem_stall), .fwd_sel_o(sel_a), .stall_id_o(stall_a)
`ifdef FWD_HAZARD_STATS_EN
    , .stall_cnt_o(scnt_a), .fwd_cnt_o(fcnt_a)
`endif
  );

  fwd_hazard_unit #(.REG_AW(5), .NUM_SRC(2), .FWD_DEPTH(3), .LOAD_LAT(2)) dut_b (
    .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_rs_i(id_rs), .id_rd_i(id_rd),
    .id_regwrite_i(id_regwrite), .id_load_i(id_load), .flush_i(flush),
    .mem_stall_i(mem_stall), .fwd_sel_o(sel_b), .stall_id_o(stall_b)
`ifdef FWD_HAZARD_STATS_EN
    , .stall_cnt_o(scnt_b), .fwd_cnt_o(fcnt_b)
`endif
  );

  typedef struct {
    string      name;
    int         which;
    logic [3:0] sel;
    logic       stall;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Monitor: one expectation per driven cycle, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t       e;
    logic [3:0] as;
    logic       ast;
    if (q.size() > 0) begin
      e   = q.pop_front();
      as  = (e.which == 1) ? sel_b : sel_a;
      ast = (e.which == 1) ? stall_b : stall_a;
      n_chk++;
      if (as !== e.sel) begin
        n_fail++;
        $display("FAIL %s fwd_sel: got %h expected %h", e.name, as, e.sel);
      end
      n_chk++;
      if (ast !== e.stall) begin
        n_fail++;
        $display("FAIL %s stall_id: got %b expected %b", e.name, ast, e.stall);
      end
    end
  end

  task automatic step(input string name, input int which,
                      input logic v, input logic [4:0] rs0, input logic [4:0] rs1,
                      input logic [4:0] rd, input logic we, input logic ld,
                      input logic fl, input logic ms,
                      input logic [1:0] s0, input logic [1:0] s1, input logic st);
    exp_t e;
    id_valid    = v;
    id_rs       = {rs1, rs0};
    id_rd       = rd;
    id_regwrite = we;
    id_load     = ld;
    flush       = fl;
    mem_stall   = ms;
    e.name  = name;
    e.which = which;
    e.sel   = {s1, s0};
    e.stall = st;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    id_valid = 1'b0; id_rs = '0; id_rd = '0; id_regwrite = 1'b0;
    id_load = 1'b0; flush = 1'b0; mem_stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    do_reset();
    step("reset_a", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("reset_b", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // add r3=r1+r2 ; sub r4=r3-r5
    step("t1_add", 0, 1, 1, 2, 3, 1, 0, 0, 0, 0, 0, 0);
    step("t1_sub", 0, 1, 3, 5, 4, 1, 0, 0, 0, 0, 0, 0);
    step("t1_fwd", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);

    // lw r7 ; add r8=r7+r7
    do_reset();
    step("t2_lw",    0, 1, 1, 0, 7, 1, 1, 0, 0, 0, 0, 0);
    step("t2_stall", 0, 1, 7, 7, 8, 1, 0, 0, 0, 0, 0, 1);
    step("t2_clear", 0, 1, 7, 7, 8, 1, 0, 0, 0, 0, 0, 0);
    step("t2_fwd",   0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 2, 0);

    // two writers of r9, then use; lw to r0 then use of r0
    do_reset();
    step("t3_add1", 0, 1, 1, 2, 9, 1, 0, 0, 0, 0, 0, 0);
    step("t3_add2", 0, 1, 3, 4, 9, 1, 0, 0, 0, 0, 0, 0);
    step("t3_use",  0, 1, 9, 9, 10, 1, 0, 0, 0, 0, 0, 0);
    step("t3_near", 0, 1, 1, 1, 0, 1, 1, 0, 0, 1, 1, 0);
    step("t3_r0id", 0, 1, 0, 0, 11, 1, 0, 0, 0, 0, 0, 0);
    step("t3_r0ex", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // lw r6 ; use r6 with a 3-cycle memory stall during the hazard
    do_reset();
    step("t4_lw",    0, 1, 1, 0, 6, 1, 1, 0, 0, 0, 0, 0);
    step("t4_ms1",   0, 1, 6, 2, 12, 1, 0, 0, 1, 0, 0, 1);
    step("t4_ms2",   0, 1, 6, 2, 12, 1, 0, 0, 1, 0, 0, 1);
    step("t4_ms3",   0, 1, 6, 2, 12, 1, 0, 0, 1, 0, 0, 1);
    step("t4_rel",   0, 1, 6, 2, 12, 1, 0, 0, 0, 0, 0, 1);
    step("t4_clear", 0, 1, 6, 2, 12, 1, 0, 0, 0, 0, 0, 0);
    step("t4_fwd",   0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0);

    // flushed writer of r5 ; use r5 ; then flush coinciding with a stall
    do_reset();
    step("t5_flush",   0, 1, 1, 2, 5, 1, 0, 1, 0, 0, 0, 0);
    step("t5_use",     0, 1, 5, 5, 13, 1, 0, 0, 0, 0, 0, 0);
    step("t5_nofwd",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("t5_lw",      0, 1, 1, 0, 7, 1, 1, 0, 0, 0, 0, 0);
    step("t5_flstall", 0, 1, 7, 0, 15, 1, 0, 1, 0, 0, 0, 1);
    step("t5_bub1",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("t5_bub2",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // FWD_DEPTH=3, LOAD_LAT=2: lw r2 ; immediate use
    do_reset();
    step("t6_lw",     1, 1, 1, 0, 2, 1, 1, 0, 0, 0, 0, 0);
    step("t6_stall1", 1, 1, 2, 3, 14, 1, 0, 0, 0, 0, 0, 1);
    step("t6_stall2", 1, 1, 2, 3, 14, 1, 0, 0, 0, 0, 0, 1);
    step("t6_clear",  1, 1, 2, 3, 14, 1, 0, 0, 0, 0, 0, 0);
    step("t6_fwd",    1, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0);
`ifdef FWD_HAZARD_STATS_EN
    n_chk++;
    if (scnt_b !== 32'd2) begin
      n_fail++;
      $display("FAIL t6_stall_cnt: got %0d expected 2", scnt_b);
    end
    n_chk++;
    if (fcnt_b !== 32'd1) begin
      n_fail++;
      $display("FAIL t6_fwd_cnt: got %0d expected 1", fcnt_b);
    end
`endif
    step("t6_after",  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
